// File: rtl/aes_out_serializer.sv
// ---------------------------------------------------------------------------
// aes_out_serializer
//
// Downstream stage of the AES core. The core emits each 128-bit cipher block
// as a one-cycle pulse and cannot stall. This block does three things:
//   - captures every pulse into a small circular buffer of whole blocks
//   - streams the oldest buffered block out as WORD_W-bit words, most
//     significant word first, over a valid/ready interface
//   - drops blocks that arrive while the buffer is full and flags the drop
//     with a sticky overflow bit
//
// Parameters
//   DATA_LEN  cipher block width (must match the core)
//   WORD_W    output word width; DATA_LEN must be a multiple of it
//   DEPTH     number of buffered blocks; power of two, at least 2
//
// Ports
//   clk             system clock, rising edge
//   reset           asynchronous, active-high reset
//   block_valid_in  one-cycle capture pulse from the core
//   block_in        cipher block, sampled only with block_valid_in
//   m_valid         output word valid
//   m_data          output word (zero while m_valid is low)
//   m_last          marks the final word of a block
//   m_ready         consumer accepts the word when m_valid && m_ready
//   overflow        sticky flag: a block was dropped on a full buffer
//   overflow_clr    synchronous clear of overflow (a same-cycle drop wins)
//   blocks_pending  blocks held, including the one being streamed
// ---------------------------------------------------------------------------
module aes_out_serializer #(
  parameter int DATA_LEN = 128,
  parameter int WORD_W   = 32,
  parameter int DEPTH    = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     block_valid_in,
  input  logic [DATA_LEN-1:0]      block_in,
  output logic                     m_valid,
  output logic [WORD_W-1:0]        m_data,
  output logic                     m_last,
  input  logic                     m_ready,
  output logic                     overflow,
  input  logic                     overflow_clr,
  output logic [$clog2(DEPTH):0]   blocks_pending
);

  localparam int NW    = DATA_LEN / WORD_W;
  localparam int IDX_W = (NW > 1) ? $clog2(NW) : 1;
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(DEPTH);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NW - 1);

  logic [DATA_LEN-1:0] mem [DEPTH];
  logic [DATA_LEN-1:0] head;
  logic [PTR_W-1:0]    wr_ptr;
  logic [PTR_W-1:0]    rd_ptr;
  logic [CNT_W-1:0]    count;
  logic [IDX_W-1:0]    word_idx;

  logic accept;
  logic last_accept;
  logic slot_free;
  logic capture;
  logic drop;

  // Handshake and capture decisions. A full buffer still has room for a new
  // block when the head block's final word leaves in the same cycle, so the
  // core never loses a block just because the pop and the push coincide.
  // The output word is picked from the head entry by word index, MSW first.
  always_comb begin
    head           = mem[rd_ptr];
    m_valid        = (count != '0);
    m_last         = m_valid && (word_idx == LAST_IDX);
    accept         = m_valid && m_ready;
    last_accept    = accept && (word_idx == LAST_IDX);
    slot_free      = (count < DEPTH_C) || last_accept;
    capture        = block_valid_in && slot_free;
    drop           = block_valid_in && !slot_free;
    blocks_pending = count;
    m_data         = '0;
    if (m_valid) begin
      m_data = head[DATA_LEN - 1 - WORD_W * int'(word_idx) -: WORD_W];
    end
  end

  // Block storage. Contents are not reset; an entry is only ever read while
  // count says it holds a captured block.
  always_ff @(posedge clk) begin
    if (capture) begin
      mem[wr_ptr] <= block_in;
    end
  end

  // Pointer, occupancy, word index and overflow bookkeeping. Pointers wrap
  // naturally because DEPTH is a power of two. A push and a final-word pop
  // in the same cycle leave count unchanged while both pointers advance.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      word_idx <= '0;
      overflow <= 1'b0;
    end else begin
      if (capture) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (accept) begin
        if (last_accept) begin
          word_idx <= '0;
          rd_ptr   <= rd_ptr + 1'b1;
        end else begin
          word_idx <= word_idx + 1'b1;
        end
      end
      case ({capture, last_accept})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (drop) begin
        overflow <= 1'b1;
      end else if (overflow_clr) begin
        overflow <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_aes_out_serializer.sv
// ---------------------------------------------------------------------------
// tb_aes_out_serializer
//
// Self-checking bench for aes_out_serializer (default parameters).
// A queue-of-blocks reference model tracks what the serializer should hold
// and present; hand-written vector tables pin the known-answer streams, and
// short scripted sequences cover overflow, full-buffer pop/push and reset.
// ---------------------------------------------------------------------------
module tb_aes_out_serializer;

  localparam int DATA_LEN = 128;
  localparam int WORD_W   = 32;
  localparam int DEPTH    = 2;
  localparam int NW       = DATA_LEN / WORD_W;

  localparam logic [127:0] BLK_P = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] BLK_Q = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  logic                clk;
  logic                reset;
  logic                block_valid_in;
  logic [DATA_LEN-1:0] block_in;
  logic                m_valid;
  logic [WORD_W-1:0]   m_data;
  logic                m_last;
  logic                m_ready;
  logic                overflow;
  logic                overflow_clr;
  logic [1:0]          blocks_pending;

  int checks;
  int failures;

  logic [127:0] mq[$];
  int           mwidx;
  bit           movf;
  logic [31:0]  acc_q[$];

  typedef struct {
    logic         valid;
    logic [127:0] blk;
    logic         ready;
    logic [31:0]  e_data;
    logic         e_valid;
    logic         e_last;
    logic [1:0]   e_pend;
  } vec_t;

  vec_t vecs[$];

  aes_out_serializer #(
    .DATA_LEN(DATA_LEN),
    .WORD_W  (WORD_W),
    .DEPTH   (DEPTH)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .block_valid_in (block_valid_in),
    .block_in       (block_in),
    .m_valid        (m_valid),
    .m_data         (m_data),
    .m_last         (m_last),
    .m_ready        (m_ready),
    .overflow       (overflow),
    .overflow_clr   (overflow_clr),
    .blocks_pending (blocks_pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Word k of a block, most significant first.
  function automatic logic [31:0] word_of(input logic [127:0] b, input int k);
    logic [127:0] t;
    t = b >> ((NW - 1 - k) * WORD_W);
    return t[31:0];
  endfunction

  function automatic logic [127:0] rand_block();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    mwidx = 0;
    movf  = 1'b0;
  endtask

  // One clock edge of the reference model, using the pre-edge state.
  task automatic model_step(input logic valid, input logic [127:0] blk,
                            input logic ready, input logic clr);
    bit acc;
    bit lastacc;
    bit room;
    acc     = (mq.size() != 0) && ready;
    lastacc = acc && (mwidx == NW - 1);
    room    = (mq.size() < DEPTH) || lastacc;
    if (acc) begin
      if (lastacc) begin
        void'(mq.pop_front());
        mwidx = 0;
      end else begin
        mwidx++;
      end
    end
    if (valid && room) mq.push_back(blk);
    if (valid && !room) movf = 1'b1;
    else if (clr)       movf = 1'b0;
  endtask

  // Drive inputs, log any word accepted at the coming edge, advance the
  // model, then land 1 time unit after the rising edge.
  task automatic applyStimulus(input logic valid, input logic [127:0] blk,
                               input logic ready, input logic clr);
    block_valid_in = valid;
    block_in       = blk;
    m_ready        = ready;
    overflow_clr   = clr;
    #1;
    if (m_valid && ready) acc_q.push_back(m_data);
    model_step(valid, blk, ready, clr);
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag);
    logic        e_valid;
    logic [31:0] e_data;
    logic        e_last;
    e_valid = (mq.size() != 0);
    e_data  = e_valid ? word_of(mq[0], mwidx) : 32'h0;
    e_last  = e_valid && (mwidx == NW - 1);
    check({tag, " m_valid"},  {127'h0, m_valid},  {127'h0, e_valid});
    check({tag, " m_data"},   {96'h0, m_data},    {96'h0, e_data});
    check({tag, " m_last"},   {127'h0, m_last},   {127'h0, e_last});
    check({tag, " pending"},  {126'h0, blocks_pending}, 128'(mq.size()));
    check({tag, " overflow"}, {127'h0, overflow}, {127'h0, movf});
  endtask

  task automatic add_vec(input logic valid, input logic [127:0] blk, input logic ready,
                         input logic [31:0] d, input logic v, input logic l,
                         input logic [1:0] p);
    vec_t r;
    r.valid = valid; r.blk = blk; r.ready = ready;
    r.e_data = d; r.e_valid = v; r.e_last = l; r.e_pend = p;
    vecs.push_back(r);
  endtask

  initial begin
    checks         = 0;
    failures       = 0;
    reset          = 1'b1;
    block_valid_in = 1'b0;
    block_in       = '0;
    m_ready        = 1'b0;
    overflow_clr   = 1'b0;
    model_reset();

    // Known-answer streams: FIPS-197 single block, back-pressure, back-to-back.
    add_vec(1, BLK_P, 1, 32'h3925841d, 1, 0, 2'd1);
    add_vec(0, '0,    1, 32'h02dc09fb, 1, 0, 2'd1);
    add_vec(0, '0,    1, 32'hdc118597, 1, 0, 2'd1);
    add_vec(0, '0,    1, 32'h196a0b32, 1, 1, 2'd1);
    add_vec(0, '0,    1, 32'h00000000, 0, 0, 2'd0);
    add_vec(1, BLK_P, 0, 32'h3925841d, 1, 0, 2'd1);
    add_vec(0, '0,    1, 32'h02dc09fb, 1, 0, 2'd1);
    add_vec(0, '0,    0, 32'h02dc09fb, 1, 0, 2'd1);
    add_vec(0, '0,    0, 32'h02dc09fb, 1, 0, 2'd1);
    add_vec(0, '0,    1, 32'hdc118597, 1, 0, 2'd1);
    add_vec(0, '0,    0, 32'hdc118597, 1, 0, 2'd1);
    add_vec(0, '0,    1, 32'h196a0b32, 1, 1, 2'd1);
    add_vec(0, '0,    1, 32'h00000000, 0, 0, 2'd0);
    add_vec(1, BLK_P, 1, 32'h3925841d, 1, 0, 2'd1);
    add_vec(1, BLK_Q, 1, 32'h02dc09fb, 1, 0, 2'd2);
    add_vec(0, '0,    1, 32'hdc118597, 1, 0, 2'd2);
    add_vec(0, '0,    1, 32'h196a0b32, 1, 1, 2'd2);
    add_vec(0, '0,    1, 32'h69c4e0d8, 1, 0, 2'd1);
    add_vec(0, '0,    1, 32'h6a7b0430, 1, 0, 2'd1);
    add_vec(0, '0,    1, 32'hd8cdb780, 1, 0, 2'd1);
    add_vec(0, '0,    1, 32'h70b4c55a, 1, 1, 2'd1);
    add_vec(0, '0,    1, 32'h00000000, 0, 0, 2'd0);

    repeat (2) @(posedge clk);
    #1;
    check("reset m_valid",  {127'h0, m_valid},  128'h0);
    check("reset m_data",   {96'h0, m_data},    128'h0);
    check("reset m_last",   {127'h0, m_last},   128'h0);
    check("reset overflow", {127'h0, overflow}, 128'h0);
    check("reset pending",  {126'h0, blocks_pending}, 128'h0);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i].valid, vecs[i].blk, vecs[i].ready, 1'b0);
      check($sformatf("vec%0d m_data", i),  {96'h0, m_data},   {96'h0, vecs[i].e_data});
      check($sformatf("vec%0d m_valid", i), {127'h0, m_valid}, {127'h0, vecs[i].e_valid});
      check($sformatf("vec%0d m_last", i),  {127'h0, m_last},  {127'h0, vecs[i].e_last});
      check($sformatf("vec%0d pending", i), {126'h0, blocks_pending}, {126'h0, vecs[i].e_pend});
      checkOutput("vec model");
    end

    // Overflow: third block dropped, only A and B come out, then clear.
    acc_q.delete();
    applyStimulus(1, 128'hA0A1A2A3_A4A5A6A7_A8A9AAAB_ACADAEAF, 0, 0);
    applyStimulus(1, 128'hB0B1B2B3_B4B5B6B7_B8B9BABB_BCBDBEBF, 0, 0);
    applyStimulus(1, 128'hC0C1C2C3_C4C5C6C7_C8C9CACB_CCCDCECF, 0, 0);
    check("ovf flag set", {127'h0, overflow}, 128'h1);
    check("ovf pending",  {126'h0, blocks_pending}, 128'h2);
    for (int i = 0; i < 10; i++) begin
      applyStimulus(0, '0, 1, 0);
      checkOutput("ovf drain");
    end
    check("ovf accepted count", 128'(acc_q.size()), 128'd8);
    for (int i = 0; i < acc_q.size() && i < 8; i++) begin
      check($sformatf("ovf word%0d", i), {96'h0, acc_q[i]},
            {96'h0, word_of((i < 4) ? 128'hA0A1A2A3_A4A5A6A7_A8A9AAAB_ACADAEAF
                                    : 128'hB0B1B2B3_B4B5B6B7_B8B9BABB_BCBDBEBF, i % 4)});
    end
    check("ovf sticky", {127'h0, overflow}, 128'h1);
    applyStimulus(0, '0, 0, 1);
    check("ovf cleared", {127'h0, overflow}, 128'h0);
    applyStimulus(0, '0, 0, 0);
    check("ovf stays clear", {127'h0, overflow}, 128'h0);

    // Full buffer: push C on the very edge that pops the last word of A.
    applyStimulus(1, BLK_P, 0, 0);
    applyStimulus(1, BLK_Q, 0, 0);
    for (int i = 0; i < 3; i++) applyStimulus(0, '0, 1, 0);
    check("full last shown", {127'h0, m_last}, 128'h1);
    check("full pending",    {126'h0, blocks_pending}, 128'h2);
    acc_q.delete();
    applyStimulus(1, 128'hC0C1C2C3_C4C5C6C7_C8C9CACB_CCCDCECF, 1, 0);
    check("full ovf clear", {127'h0, overflow}, 128'h0);
    check("full pending2",  {126'h0, blocks_pending}, 128'h2);
    check("full next word", {96'h0, m_data}, {96'h0, 32'h69c4e0d8});
    for (int i = 0; i < 9; i++) begin
      applyStimulus(0, '0, 1, 0);
      checkOutput("full drain");
    end
    check("full accepted count", 128'(acc_q.size()), 128'd9);
    for (int i = 1; i < acc_q.size() && i < 9; i++) begin
      check($sformatf("full word%0d", i), {96'h0, acc_q[i]},
            {96'h0, word_of((i < 5) ? BLK_Q : 128'hC0C1C2C3_C4C5C6C7_C8C9CACB_CCCDCECF,
                            (i - 1) % 4)});
    end

    // Reset after two words of a block have been accepted.
    applyStimulus(1, BLK_P, 1, 0);
    applyStimulus(0, '0, 1, 0);
    applyStimulus(0, '0, 1, 0);
    check("pre-reset word", {96'h0, m_data}, {96'h0, 32'hdc118597});
    @(negedge clk);
    reset = 1'b1;
    #1;
    model_reset();
    check("midrst m_valid", {127'h0, m_valid}, 128'h0);
    check("midrst m_data",  {96'h0, m_data},   128'h0);
    check("midrst pending", {126'h0, blocks_pending}, 128'h0);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    acc_q.delete();
    for (int i = 0; i < 5; i++) begin
      applyStimulus(0, '0, 1, 0);
      checkOutput("post-reset idle");
    end
    check("post-reset no words", 128'(acc_q.size()), 128'd0);
    applyStimulus(1, BLK_Q, 1, 0);
    checkOutput("post-reset new block");

    // Random traffic against the reference model.
    for (int i = 0; i < 400; i++) begin
      applyStimulus($urandom_range(0, 9) < 3, rand_block(),
                    $urandom_range(0, 9) < 6, $urandom_range(0, 19) == 0);
      checkOutput("rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
